// File: rtl/core_alu_register.sv
// core_alu_register: 8-bit combinational ALU with 6502-style N/V/Z/C flags,
// plus an enable-strobed output register with a synchronous, parameterised reset.
module core_alu_register #(
    parameter logic [7:0] RESET_RESULT = 8'h00,
    parameter logic [3:0] RESET_FLAGS  = 4'h0
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_enable,
    input  logic [3:0] I_control,
    input  logic [7:0] I_lhs,
    input  logic [7:0] I_rhs,
    input  logic       I_carry,
    input  logic       I_overflow,
    input  logic       I_sign,
    input  logic       I_zero,
    output logic [7:0] O_result,
    output logic       O_carry,
    output logic       O_overflow,
    output logic       O_sign,
    output logic       O_zero,
    output logic [7:0] O_reg_result,
    output logic [3:0] O_reg_flags
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ORA  = 4'd1,
        OP_AND  = 4'd2,
        OP_EOR  = 4'd3,
        OP_ADC  = 4'd4,
        OP_SBC  = 4'd5,
        OP_CMP  = 4'd6,
        OP_BIT  = 4'd7,
        OP_ASL  = 4'd8,
        OP_LSR  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11,
        OP_INC  = 4'd12,
        OP_DEC  = 4'd13,
        OP_PASS = 4'd14,
        OP_RSVD = 4'd15
    } aluOp_e;

    aluOp_e     op;
    logic [8:0] sumWide;
    logic [7:0] resultComb;
    logic       carryComb;
    logic       overflowComb;
    logic       signComb;
    logic       zeroComb;
    logic [7:0] regResult_q, regResult_d;
    logic [3:0] regFlags_q,  regFlags_d;

    assign op = aluOp_e'(I_control);

    // ALU datapath: every flag defaults to its incoming value, and each op
    // overrides only the flags it defines; N/Z derive from the result last.
    always_comb begin
        sumWide      = 9'd0;
        resultComb   = I_lhs;
        carryComb    = I_carry;
        overflowComb = I_overflow;
        signComb     = I_sign;
        zeroComb     = I_zero;
        unique case (op)
            OP_ORA: resultComb = I_lhs | I_rhs;
            OP_AND: resultComb = I_lhs & I_rhs;
            OP_EOR: resultComb = I_lhs ^ I_rhs;
            OP_ADC: begin
                sumWide      = {1'b0, I_lhs} + {1'b0, I_rhs} + {8'd0, I_carry};
                resultComb   = sumWide[7:0];
                carryComb    = sumWide[8];
                overflowComb = (I_lhs[7] == I_rhs[7]) && (resultComb[7] != I_lhs[7]);
            end
            OP_SBC: begin
                sumWide      = {1'b0, I_lhs} + {1'b0, ~I_rhs} + {8'd0, I_carry};
                resultComb   = sumWide[7:0];
                carryComb    = sumWide[8];
                overflowComb = (I_lhs[7] != I_rhs[7]) && (resultComb[7] != I_lhs[7]);
            end
            OP_CMP: begin
                resultComb = I_lhs - I_rhs;
                carryComb  = (I_lhs >= I_rhs);
            end
            OP_BIT: begin
                resultComb   = I_lhs & I_rhs;
                overflowComb = I_rhs[6];
            end
            OP_ASL: begin
                resultComb = {I_lhs[6:0], 1'b0};
                carryComb  = I_lhs[7];
            end
            OP_LSR: begin
                resultComb = {1'b0, I_lhs[7:1]};
                carryComb  = I_lhs[0];
            end
            OP_ROL: begin
                resultComb = {I_lhs[6:0], I_carry};
                carryComb  = I_lhs[7];
            end
            OP_ROR: begin
                resultComb = {I_carry, I_lhs[7:1]};
                carryComb  = I_lhs[0];
            end
            OP_INC:  resultComb = I_lhs + 8'd1;
            OP_DEC:  resultComb = I_lhs - 8'd1;
            OP_PASS: resultComb = I_rhs;
            default: resultComb = I_lhs;
        endcase
        if ((op != OP_NOP) && (op != OP_RSVD)) begin
            zeroComb = (resultComb == 8'd0);
            signComb = (op == OP_BIT) ? I_rhs[7] : resultComb[7];
        end
    end

    assign O_result   = resultComb;
    assign O_carry    = carryComb;
    assign O_overflow = overflowComb;
    assign O_sign     = signComb;
    assign O_zero     = zeroComb;

    // Next-state for the output register: capture on enable, otherwise hold.
    always_comb begin
        regResult_d = regResult_q;
        regFlags_d  = regFlags_q;
        if (I_enable) begin
            regResult_d = resultComb;
            regFlags_d  = {signComb, overflowComb, zeroComb, carryComb};
        end
    end

    // Output register; reset is sampled on the edge and overrides a capture.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            regResult_q <= RESET_RESULT;
            regFlags_q  <= RESET_FLAGS;
        end else begin
            regResult_q <= regResult_d;
            regFlags_q  <= regFlags_d;
        end
    end

    assign O_reg_result = regResult_q;
    assign O_reg_flags  = regFlags_q;

endmodule

// File: tb/tb_core_alu_register.sv
// Testbench for core_alu_register: arithmetic reference model, per-cycle
// comparison of combinational and registered outputs, plus literal vectors.
module tb_core_alu_register;

    logic       I_clock = 1'b0;
    logic       I_reset = 1'b0;
    logic       I_enable = 1'b0;
    logic [3:0] I_control = 4'd0;
    logic [7:0] I_lhs = 8'd0;
    logic [7:0] I_rhs = 8'd0;
    logic       I_carry = 1'b0;
    logic       I_overflow = 1'b0;
    logic       I_sign = 1'b0;
    logic       I_zero = 1'b0;
    logic [7:0] O_result;
    logic       O_carry;
    logic       O_overflow;
    logic       O_sign;
    logic       O_zero;
    logic [7:0] O_reg_result;
    logic [3:0] O_reg_flags;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [11:0] expReg      = 12'h000;
    bit          regKnown    = 1'b0;

    core_alu_register dut (
        .I_clock     (I_clock),
        .I_reset     (I_reset),
        .I_enable    (I_enable),
        .I_control   (I_control),
        .I_lhs       (I_lhs),
        .I_rhs       (I_rhs),
        .I_carry     (I_carry),
        .I_overflow  (I_overflow),
        .I_sign      (I_sign),
        .I_zero      (I_zero),
        .O_result    (O_result),
        .O_carry     (O_carry),
        .O_overflow  (O_overflow),
        .O_sign      (O_sign),
        .O_zero      (O_zero),
        .O_reg_result(O_reg_result),
        .O_reg_flags (O_reg_flags)
    );

    // 100 MHz-style free-running clock.
    always #5 I_clock = ~I_clock;

    // Reference ALU: plain integer arithmetic, signed range checks for V.
    // Returns {result[7:0], N, V, Z, C}.
    function automatic logic [11:0] aluModel(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic ci,
                                             input logic vi, input logic ni, input logic zi);
        int ia, ib, ic, sa, sb, r, sr, r8;
        logic c, v, n, z;
        bit nzFromResult;
        logic [7:0] res;
        ia = int'(a); ib = int'(b); ic = int'(ci);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        c = ci; v = vi; n = ni; z = zi;
        r = ia;
        nzFromResult = 1'b1;
        case (op)
            4'd1:  r = int'(a | b);
            4'd2:  r = int'(a & b);
            4'd3:  r = int'(a ^ b);
            4'd4:  begin
                r  = ia + ib + ic;
                c  = (r > 255);
                sr = sa + sb + ic;
                v  = (sr > 127) || (sr < -128);
            end
            4'd5:  begin
                r  = ia - ib - (1 - ic);
                c  = (r >= 0);
                sr = sa - sb - (1 - ic);
                v  = (sr > 127) || (sr < -128);
            end
            4'd6:  begin r = ia - ib; c = (ia >= ib); end
            4'd7:  begin r = int'(a & b); v = b[6]; end
            4'd8:  begin r = ia * 2; c = (ia >= 128); end
            4'd9:  begin r = ia / 2; c = (ia % 2 == 1); end
            4'd10: begin r = ia * 2 + ic; c = (ia >= 128); end
            4'd11: begin r = ia / 2 + ic * 128; c = (ia % 2 == 1); end
            4'd12: r = ia + 1;
            4'd13: r = ia - 1;
            4'd14: r = ib;
            default: nzFromResult = 1'b0;
        endcase
        r8  = ((r % 256) + 256) % 256;
        res = r8[7:0];
        if (nzFromResult) begin
            z = (r8 == 0);
            n = (op == 4'd7) ? b[7] : (r8 >= 128);
        end
        return {res, n, v, z, c};
    endfunction

    // Drive all DUT inputs at once.
    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] op,
                                 input logic [7:0] a, input logic [7:0] b, input logic [3:0] nvzc);
        I_reset    = rst;
        I_enable   = en;
        I_control  = op;
        I_lhs      = a;
        I_rhs      = b;
        I_sign     = nvzc[3];
        I_overflow = nvzc[2];
        I_zero     = nvzc[1];
        I_carry    = nvzc[0];
    endtask

    // Compare an observed value against a required one and record the outcome.
    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Expected register contents, advanced with the same edge the DUT uses.
    always @(posedge I_clock) begin
        if (I_reset) begin
            expReg   = {8'h00, 4'h0};
            regKnown = 1'b1;
        end else if (I_enable) begin
            expReg = aluModel(I_control, I_lhs, I_rhs, I_carry, I_overflow, I_sign, I_zero);
        end
    end

    // Per-cycle compare on the falling edge, away from the capture edge.
    always @(negedge I_clock) begin
        checkOutput("comb", {O_result, O_sign, O_overflow, O_zero, O_carry},
                    aluModel(I_control, I_lhs, I_rhs, I_carry, I_overflow, I_sign, I_zero));
        if (regKnown)
            checkOutput("reg", {O_reg_result, O_reg_flags}, expReg);
    end

    // Apply a vector just after a rising edge, then check the comb outputs.
    task automatic directed(input string name, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] nvzc, input logic [11:0] required);
        @(posedge I_clock);
        #1;
        applyStimulus(1'b0, 1'b0, op, a, b, nvzc);
        #1;
        checkOutput(name, {O_result, O_sign, O_overflow, O_zero, O_carry}, required);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 4'h0);
        @(posedge I_clock);
        #1;
        checkOutput("reset_state", {O_reg_result, O_reg_flags}, 12'h000);

        // Literal vectors, given as {result, N, V, Z, C}.
        directed("adc_50_50",  4'd4,  8'h50, 8'h50, 4'b0000, {8'hA0, 4'b1100});
        directed("sbc_00_01",  4'd5,  8'h00, 8'h01, 4'b0001, {8'hFF, 4'b1000});
        directed("sbc_80_01",  4'd5,  8'h80, 8'h01, 4'b0001, {8'h7F, 4'b0101});
        directed("cmp_eq",     4'd6,  8'h40, 8'h40, 4'b0100, {8'h00, 4'b0111});
        directed("cmp_lt",     4'd6,  8'h3F, 8'h40, 4'b0100, {8'hFF, 4'b1100});
        directed("ror_01_c1",  4'd11, 8'h01, 8'h00, 4'b0001, {8'h80, 4'b1001});
        directed("bit_0f_c0",  4'd7,  8'h0F, 8'hC0, 4'b0000, {8'h00, 4'b1110});
        directed("inc_ff",     4'd12, 8'hFF, 8'h00, 4'b0101, {8'h00, 4'b0111});
        directed("dec_00",     4'd13, 8'h00, 8'h00, 4'b0000, {8'hFF, 4'b1000});
        directed("nop_pass",   4'd0,  8'h5A, 8'h33, 4'b1011, {8'h5A, 4'b1011});
        directed("rsvd_pass",  4'd15, 8'hC3, 8'h11, 4'b0110, {8'hC3, 4'b0110});
        directed("lsr_81",     4'd9,  8'h81, 8'h00, 4'b1000, {8'h40, 4'b0001});

        // Register sequence: capture, hold, reset-wins.
        @(posedge I_clock);
        #1;
        applyStimulus(1'b0, 1'b1, 4'd4, 8'h01, 8'h01, 4'b0000);
        @(posedge I_clock);
        #1;
        checkOutput("reg_capture", {4'h0, O_reg_result}, 12'h002);
        applyStimulus(1'b0, 1'b0, 4'd1, 8'hF0, 8'h0F, 4'b1111);
        @(posedge I_clock);
        #1;
        checkOutput("reg_hold", {4'h0, O_reg_result}, 12'h002);
        applyStimulus(1'b1, 1'b1, 4'd14, 8'h00, 8'h77, 4'b0000);
        @(posedge I_clock);
        #1;
        checkOutput("reg_reset_wins", {O_reg_result, O_reg_flags}, 12'h000);

        // Randomised traffic with sporadic resets and enables.
        for (int i = 0; i < 400; i++) begin
            @(posedge I_clock);
            #1;
            applyStimulus(($urandom_range(15) == 0), $urandom_range(1) == 1,
                          4'($urandom_range(15)), 8'($urandom), 8'($urandom),
                          4'($urandom_range(15)));
        end
        @(posedge I_clock);
        #1;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'h0);
        @(negedge I_clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/core_alu_register.md
CORE_ALU_REGISTER -- requirements
Module: core_alu_register

Interface
REQ-001 SHALL have parameter RESET_RESULT, default 8'h00, value loaded into O_reg_result on reset.
REQ-002 SHALL have parameter RESET_FLAGS, default 4'h0, value loaded into O_reg_flags ({N,V,Z,C}) on reset.
REQ-003 SHALL have port I_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port I_reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port I_enable, input, 1, latch strobe for the output register.
REQ-006 SHALL have port I_control, input, 4, operation select per REQ-013.
REQ-007 SHALL have ports I_lhs and I_rhs, input, 8 each, operands.
REQ-008 SHALL have ports I_carry, I_overflow, I_sign, I_zero, input, 1 each, incoming C/V/N/Z flags.
REQ-009 SHALL have port O_result, output, 8, combinational ALU result.
REQ-010 SHALL have ports O_carry, O_overflow, O_sign, O_zero, output, 1 each, combinational outgoing flags.
REQ-011 SHALL have port O_reg_result, output, 8, registered copy of O_result.
REQ-012 SHALL have port O_reg_flags, output, 4, registered {O_sign, O_overflow, O_zero, O_carry}.

Function
REQ-013 I_control encoding SHALL be: 0 NOP, 1 ORA, 2 AND, 3 EOR, 4 ADC, 5 SBC, 6 CMP, 7 BIT, 8 ASL, 9 LSR, 10 ROL, 11 ROR, 12 INC, 13 DEC, 14 PASS (rhs), 15 reserved.
REQ-014 ALU path SHALL be purely combinational (zero latency); any flag not named for an op SHALL pass through from its input.
REQ-015 NOP and reserved code 15 SHALL give result = I_lhs with all four flags passed through.
REQ-016 ORA/AND/EOR SHALL give lhs|rhs, lhs&rhs, lhs^rhs; N = result[7], Z = (result == 0).
REQ-017 ADC SHALL be binary only (no decimal mode): 9-bit sum = lhs + rhs + I_carry; result = sum[7:0]; C = sum[8]; V = (lhs[7] == rhs[7]) && (result[7] != lhs[7]); N, Z from result.
REQ-018 SBC SHALL compute sum = lhs + ~rhs + I_carry (9-bit); result = sum[7:0]; C = sum[8] (1 = no borrow); V = (lhs[7] != rhs[7]) && (result[7] != lhs[7]); N, Z from result.
REQ-019 CMP SHALL give result = (lhs - rhs) mod 256; N = result[7]; Z = (lhs == rhs); C = (lhs >= rhs) unsigned; V passed.
REQ-020 BIT SHALL give result = lhs & rhs; Z = (result == 0); N = rhs[7]; V = rhs[6]; C passed.
REQ-021 ASL SHALL give {lhs[6:0],0}, C = lhs[7]; LSR SHALL give {0,lhs[7:1]}, C = lhs[0], N = 0; Z from result for both.
REQ-022 ROL SHALL give {lhs[6:0],I_carry}, C = lhs[7]; ROR SHALL give {I_carry,lhs[7:1]}, C = lhs[0]; N, Z from result.
REQ-023 INC/DEC SHALL give lhs+1 / lhs-1 with 8-bit wrap-around (FF->00, 00->FF); N, Z from result; C, V passed.
REQ-024 PASS SHALL give result = I_rhs; N, Z from result.
REQ-025 On a rising edge with I_reset low and I_enable high, O_reg_result and O_reg_flags SHALL load the current combinational values.
REQ-026 With I_enable low, the registered outputs SHALL hold their values.

Reset
REQ-027 On a rising edge with I_reset high, O_reg_result SHALL become RESET_RESULT and O_reg_flags RESET_FLAGS, regardless of I_enable (reset wins).
REQ-028 Reset SHALL have no effect between clock edges and SHALL NOT affect the combinational outputs.
REQ-029 Reset asserted mid-stream SHALL discard the pending capture for that edge; capture SHALL resume on the first edge after I_reset falls with I_enable high.

Verification
REQ-030 ADC lhs=0x50, rhs=0x50, C=0 -> result 0xA0, N=1, V=1, Z=0, C=0.
REQ-031 SBC lhs=0x00, rhs=0x01, C=1 -> result 0xFF, N=1, Z=0, C=0, V=0; SBC lhs=0x80, rhs=0x01, C=1 -> 0x7F, V=1, C=1.
REQ-032 CMP lhs=0x40, rhs=0x40 -> Z=1, C=1, N=0; lhs=0x3F, rhs=0x40 -> Z=0, C=0, N=1; incoming V unchanged.
REQ-033 ROR lhs=0x01, C=1 -> result 0x80, C=1, N=1; BIT lhs=0x0F, rhs=0xC0 -> Z=1, N=1, V=1.
REQ-034 Register: reset -> O_reg_result 0x00, O_reg_flags 0x0; enable high with ADC 0x01+0x01 -> next edge O_reg_result 0x02; enable low with new inputs -> outputs hold 0x02; I_reset and I_enable high together -> 0x00.
REQ-035 INC lhs=0xFF -> 0x00, Z=1, N=0, C unchanged; DEC lhs=0x00 -> 0xFF, N=1.
